// File: rtl/sargantana_ifill_arbiter.sv
// Shares the single L2 ifill port between icache demand misses and the next-line
// prefetcher: one fill in flight, demand first, prefetch forced after PF_STARVE losses.
module sargantana_ifill_arbiter #(
  parameter int PADDR_SIZE = 40,
  parameter int LINE_W     = 512,
  parameter int PF_STARVE  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  dmd_req_valid_i,
  input  logic [PADDR_SIZE-1:0] dmd_req_paddr_i,
  output logic                  dmd_req_ready_o,
  output logic                  dmd_resp_valid_o,
  input  logic                  pf_req_valid_i,
  input  logic [PADDR_SIZE-1:0] pf_req_paddr_i,
  output logic                  pf_req_ready_o,
  output logic                  pf_resp_valid_o,
  output logic [LINE_W-1:0]     resp_data_o,
  output logic                  ifill_req_valid_o,
  output logic [PADDR_SIZE-1:0] ifill_req_paddr_o,
  input  logic                  ifill_resp_ack_i,
  input  logic                  ifill_resp_valid_i,
  input  logic [LINE_W-1:0]     ifill_resp_data_i,
  output logic                  busy_o,
  output logic                  imiss_time_pmu_o,
  output logic [1:0]            state_dbg_o
);

  localparam int OFF = $clog2(LINE_W / 8);
  localparam int CW  = $clog2(PF_STARVE + 1);
  localparam logic [PADDR_SIZE-1:0] LINE_MASK = {{(PADDR_SIZE - OFF){1'b1}}, {OFF{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Handshake: a request is taken in the cycle its valid and ready are both high;
  // ready is combinational and only ever asserted for the single winner in IDLE.

  state_t                state;
  logic                  owner_pf;
  logic                  killed;
  logic [CW-1:0]         starve_cnt;
  logic [PADDR_SIZE-1:0] paddr;

  logic                  pf_win;
  logic                  dmd_win;
  logic                  resp_done;
  logic                  resp_fire;
  logic [PADDR_SIZE-1:0] grant_paddr;

  always_comb begin
    pf_win  = 1'b0;
    dmd_win = 1'b0;
    if (state == IDLE && !flush_i) begin
      pf_win  = pf_req_valid_i && (!dmd_req_valid_i || starve_cnt == CW'(PF_STARVE));
      dmd_win = dmd_req_valid_i && !pf_win;
    end
  end

  assign grant_paddr = (pf_win ? pf_req_paddr_i : dmd_req_paddr_i) & LINE_MASK;

  // A response only counts in REQ together with its ack, or in WAIT.
  assign resp_done = ifill_resp_valid_i &&
                     ((state == REQ && ifill_resp_ack_i) || state == WAIT);
  assign resp_fire = resp_done && !killed && !flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= IDLE;
      owner_pf         <= 1'b0;
      killed           <= 1'b0;
      starve_cnt       <= '0;
      paddr            <= '0;
      resp_data_o      <= '0;
      dmd_resp_valid_o <= 1'b0;
      pf_resp_valid_o  <= 1'b0;
    end else begin
      dmd_resp_valid_o <= resp_fire && !owner_pf;
      pf_resp_valid_o  <= resp_fire && owner_pf;
      if (resp_fire) resp_data_o <= ifill_resp_data_i;

      if (!pf_req_valid_i || pf_win) starve_cnt <= '0;
      else if (dmd_win && starve_cnt != CW'(PF_STARVE)) starve_cnt <= starve_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (pf_win || dmd_win) begin
            state    <= REQ;
            owner_pf <= pf_win;
            killed   <= 1'b0;
            paddr    <= grant_paddr;
          end
        end
        REQ: begin
          if (flush_i) killed <= 1'b1;
          if (ifill_resp_ack_i) state <= ifill_resp_valid_i ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush_i) killed <= 1'b1;
          if (ifill_resp_valid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (resp_done) killed <= 1'b0;
    end
  end

  assign dmd_req_ready_o   = dmd_win;
  assign pf_req_ready_o    = pf_win;
  assign ifill_req_valid_o = (state == REQ);
  assign ifill_req_paddr_o = paddr;
  assign busy_o            = (state != IDLE);
  assign imiss_time_pmu_o  = (state != IDLE) && !owner_pf && !killed;
  assign state_dbg_o       = state;

endmodule

// File: tb/tb_sargantana_ifill_arbiter.sv
// Bench for sargantana_ifill_arbiter: transaction-level model compared every cycle,
// grant-order scoreboard and hand-computed literals for the directed scenarios.
module tb_sargantana_ifill_arbiter;

  localparam int PA = 40;
  localparam int LW = 512;
  localparam int PS = 4;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          dmd_v = 1'b0, pf_v = 1'b0;
  logic [PA-1:0] dmd_a = '0, pf_a = '0;
  logic          ack = 1'b0, rv = 1'b0;
  logic [LW-1:0] rdata = '0;
  logic          dmd_ready, pf_ready, dmd_resp, pf_resp, req_valid, busy, pmu;
  logic [PA-1:0] req_paddr;
  logic [LW-1:0] resp_data;
  logic [1:0]    state_dbg;

  sargantana_ifill_arbiter #(.PADDR_SIZE(PA), .LINE_W(LW), .PF_STARVE(PS)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .dmd_req_valid_i(dmd_v), .dmd_req_paddr_i(dmd_a), .dmd_req_ready_o(dmd_ready),
    .dmd_resp_valid_o(dmd_resp),
    .pf_req_valid_i(pf_v), .pf_req_paddr_i(pf_a), .pf_req_ready_o(pf_ready),
    .pf_resp_valid_o(pf_resp), .resp_data_o(resp_data),
    .ifill_req_valid_o(req_valid), .ifill_req_paddr_o(req_paddr),
    .ifill_resp_ack_i(ack), .ifill_resp_valid_i(rv), .ifill_resp_data_i(rdata),
    .busy_o(busy), .imiss_time_pmu_o(pmu), .state_dbg_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  bit sb_en = 1'b0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 nothing outstanding, 1 request on the bus, 2 acked and waiting for data
  int            m_phase = 0;
  int            m_streak = 0;
  bit            m_pf = 1'b0, m_killed = 1'b0, m_dp = 1'b0, m_pp = 1'b0;
  logic [PA-1:0] m_paddr = '0;
  logic [LW-1:0] m_data = '0;
  logic          m_pfw, m_dw, m_done, m_fire;

  assign m_pfw  = (m_phase == 0) && !flush && pf_v && (!dmd_v || m_streak >= PS);
  assign m_dw   = (m_phase == 0) && !flush && dmd_v && !m_pfw;
  assign m_done = rv && ((m_phase == 1 && ack) || m_phase == 2);
  assign m_fire = m_done && !m_killed && !flush;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= 0; m_streak <= 0; m_pf <= 1'b0; m_killed <= 1'b0;
      m_dp <= 1'b0; m_pp <= 1'b0; m_paddr <= '0; m_data <= '0;
    end else begin
      m_dp <= m_fire && !m_pf;
      m_pp <= m_fire && m_pf;
      if (m_fire) m_data <= rdata;
      if (!pf_v || m_pfw) m_streak <= 0;
      else if (m_dw) m_streak <= (m_streak < PS) ? m_streak + 1 : PS;
      if (m_pfw || m_dw) begin
        m_phase  <= 1;
        m_pf     <= m_pfw;
        m_killed <= 1'b0;
        m_paddr  <= (m_pfw ? pf_a : dmd_a) & ~(40'h3f);
      end else if (m_done) begin
        m_phase  <= 0;
        m_killed <= 1'b0;
      end else begin
        if (m_phase == 1 && ack) m_phase <= 2;
        if (m_phase != 0 && flush) m_killed <= 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (run) begin
      chk("dmd_ready", dmd_ready, m_dw);
      chk("pf_ready", pf_ready, m_pfw);
      chk("req_valid", req_valid, m_phase == 1);
      if (m_phase == 1) chk("req_paddr", req_paddr, m_paddr);
      chk("busy", busy, m_phase != 0);
      chk("pmu", pmu, m_phase != 0 && !m_pf && !m_killed);
      chk("dmd_resp", dmd_resp, m_dp);
      chk("pf_resp", pf_resp, m_pp);
      chk("resp_data", resp_data, m_data);
      if (sb_en && ((dmd_v && dmd_ready) || (pf_v && pf_ready))) begin
        if (exp_q.size() == 0) chk("grant_extra", 1'b1, 1'b0);
        else chk("grant_order", pf_v && pf_ready, exp_q.pop_front());
      end
      if (ack && m_phase != 1) begin
        errors++;
        $display("FAIL protocol ack outside REQ act=1 exp=0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [PA-1:0] o_paddr[16];
  logic          o_reqv[16], o_pmu[16], o_busy[16], o_dp[16], o_pp[16];
  logic [LW-1:0] o_data[16];

  task automatic wait_grant(input string name);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 12) begin
      @(negedge clk);
      got = (dmd_v && dmd_ready) || (pf_v && pf_ready);
      @(posedge clk); #1;
      n++;
    end
    chk(name, got, 1'b1);
  endtask

  // Offsets are cycles after the accept cycle; flush_at 0 means no flush.
  task automatic fill(input bit is_pf, input logic [PA-1:0] a, input logic [LW-1:0] d,
                      input int ack_at, input int rv_at, input int flush_at);
    if (is_pf) begin pf_v = 1'b1; pf_a = a; end
    else begin dmd_v = 1'b1; dmd_a = a; end
    wait_grant("fill_grant");
    dmd_v = 1'b0; pf_v = 1'b0;
    for (int c = 1; c <= rv_at + 1; c++) begin
      ack   = (c == ack_at);
      rv    = (c == rv_at);
      rdata = (c == rv_at) ? d : '0;
      flush = (c == flush_at);
      @(negedge clk);
      o_paddr[c] = req_paddr; o_reqv[c] = req_valid; o_pmu[c] = pmu;
      o_busy[c] = busy; o_dp[c] = dmd_resp; o_pp[c] = pf_resp; o_data[c] = resp_data;
      @(posedge clk); #1;
    end
    ack = 1'b0; rv = 1'b0; flush = 1'b0;
  endtask

  localparam logic [LW-1:0] D1 = {16{32'hD1D1_0001}};
  localparam logic [LW-1:0] D2 = {16{32'hD2D2_0002}};
  localparam logic [LW-1:0] D3 = {16{32'hD3D3_0003}};
  localparam logic [LW-1:0] D4 = {16{32'hD4D4_0004}};
  localparam logic [LW-1:0] D5 = {16{32'hD5D5_0005}};
  localparam logic [LW-1:0] D6 = {16{32'hD6D6_0006}};

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    run = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_paddr", req_paddr, '0);
    chk("rst_data", resp_data, '0);
    chk("rst_pulses", {dmd_resp, pf_resp, pmu}, 3'b000);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Basic demand fill: ack at N+3, data at N+6
    fill(1'b0, 40'h8000_1234, D1, 3, 6, 0);
    for (int c = 1; c <= 3; c++) begin
      chk("t1_paddr", o_paddr[c], 40'h8000_1200);
      chk("t1_reqv", o_reqv[c], 1'b1);
    end
    chk("t1_reqv_after_ack", o_reqv[4], 1'b0);
    for (int c = 1; c <= 6; c++) chk("t1_pmu", o_pmu[c], 1'b1);
    chk("t1_pmu_done", o_pmu[7], 1'b0);
    chk("t1_no_early_pulse", o_dp[6], 1'b0);
    chk("t1_pulse", o_dp[7], 1'b1);
    chk("t1_data", o_data[7], D1);

    // Anti-starvation: both requesters held high
    sb_en = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    dmd_v = 1'b1; pf_v = 1'b1; dmd_a = 40'h1000_0047; pf_a = 40'h2000_0085;
    for (int g = 0; g < 7; g++) begin
      wait_grant("t2_grant");
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0; rv = 1'b1; rdata = {16{32'h0000_0100 + 32'(g)}};
      @(posedge clk); #1;
      rv = 1'b0;
    end
    dmd_v = 1'b0; pf_v = 1'b0;
    @(posedge clk); #1;
    sb_en = 1'b0;
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_last_data", resp_data, {16{32'h0000_0106}});

    // Flush while waiting for data
    fill(1'b0, 40'h8000_2040, D2, 1, 4, 3);
    chk("t3a_pmu_flush_cycle", o_pmu[3], 1'b1);
    chk("t3a_pmu_killed", o_pmu[4], 1'b0);
    chk("t3a_no_pulse", o_dp[5], 1'b0);
    chk("t3a_idle", o_busy[5], 1'b0);
    chk("t3a_data_held", o_data[5], {16{32'h0000_0106}});
    fill(1'b1, 40'h9000_00ff, D3, 1, 2, 0);
    chk("t3a_next_paddr", o_paddr[1], 40'h9000_00c0);
    chk("t3a_next_pulse", o_pp[3], 1'b1);
    chk("t3a_next_data", o_data[3], D3);

    // Flush in the ack cycle
    fill(1'b0, 40'h8000_3000, D4, 2, 4, 2);
    chk("t3b_no_pulse", o_dp[5], 1'b0);
    chk("t3b_idle", o_busy[5], 1'b0);
    chk("t3b_data_held", o_data[5], D3);

    // Ack and data together in REQ, then the same with flush
    fill(1'b1, 40'h9000_1111, D5, 2, 2, 0);
    chk("t4_paddr", o_paddr[2], 40'h9000_1100);
    chk("t4_pulse", o_pp[3], 1'b1);
    chk("t4_idle", o_busy[3], 1'b0);
    chk("t4_data", o_data[3], D5);
    fill(1'b0, 40'h8000_4000, D6, 1, 1, 1);
    chk("t4_flush_no_pulse", o_dp[2], 1'b0);
    chk("t4_flush_data_held", o_data[2], D5);

    // Flush in IDLE blocks the grant for that cycle only
    dmd_v = 1'b1; dmd_a = 40'h8000_5000; flush = 1'b1;
    @(negedge clk);
    chk("t5_flush_blocks", dmd_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    fill(1'b0, 40'h8000_5000, D6, 1, 2, 0);
    chk("t5_pulse", o_dp[3], 1'b1);
    chk("t5_data", o_data[3], D6);

    // Reset in WAIT, then a stray response
    dmd_v = 1'b1; dmd_a = 40'h3000_0010;
    wait_grant("t6_grant");
    dmd_v = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_req_valid", req_valid, 1'b0);
    chk("t6_paddr", req_paddr, '0);
    chk("t6_data", resp_data, '0);
    chk("t6_flags", {dmd_resp, pf_resp, pmu}, 3'b000);
    @(posedge clk); #1;
    rstn = 1'b1; rv = 1'b1; rdata = D2;
    @(posedge clk); #1;
    rv = 1'b0;
    @(negedge clk);
    chk("t6_stray_pulse", {dmd_resp, pf_resp}, 2'b00);
    chk("t6_stray_busy", busy, 1'b0);
    chk("t6_stray_data", resp_data, '0);
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
